// File: rtl/score_ctrl.sv
// score_ctrl: edge-counted game score accumulator that drives a binary-to-BCD converter
// and publishes committed digits to the renderer only on frame_tick.
module score_ctrl #(
   parameter int HIT_PTS   = 10,
   parameter int BONUS_PTS = 50,
   parameter int SCORE_MAX = 9990,
   parameter int CONV_TMO  = 63
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  enemy_hit,
   input  logic        bonus_hit,
   input  logic        frame_tick,
   input  logic        conv_done,
   input  logic [15:0] conv_bcd,
   output logic        conv_start,
   output logic [13:0] conv_in,
   output logic [13:0] score,
   output logic [15:0] disp_bcd,
   output logic        busy,
   output logic        score_maxed
);
   localparam int TW = $clog2(CONV_TMO + 2);
   typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;
   state_t state, state_n;
   logic [3:0]    hit_q, hit_rise;
   logic          bonus_q, bonus_rise;
   logic [2:0]    n_hits;
   logic [13:0]   inc, pending, pend_sum, new_score, conv_reg;
   logic [14:0]   acc, tot;
   logic [15:0]   shadow;
   logic [TW-1:0] cnt;
   logic          launch, capture, commit, cnt_inc;
   assign hit_rise    = enemy_hit & ~hit_q;
   assign bonus_rise  = bonus_hit & ~bonus_q;
   assign n_hits      = 3'(hit_rise[0]) + 3'(hit_rise[1]) + 3'(hit_rise[2]) + 3'(hit_rise[3]);
   assign inc         = 14'(HIT_PTS * int'(n_hits) + (bonus_rise ? BONUS_PTS : 0));
   assign acc         = 15'(pending) + 15'(inc);
   assign pend_sum    = acc > 15'(SCORE_MAX) ? 14'(SCORE_MAX) : acc[13:0];
   assign tot         = 15'(score) + 15'(pending);
   assign new_score   = tot > 15'(SCORE_MAX) ? 14'(SCORE_MAX) : tot[13:0];
   // conv_in shows the freshly computed score in the launch cycle, then the held copy
   assign conv_in     = launch ? new_score : conv_reg;
   assign busy        = state != IDLE;
   assign score_maxed = score == 14'(SCORE_MAX);
   always_ff @(posedge clk)
      state <= !reset ? IDLE : state_n;
   always_comb begin
      state_n    = state;
      conv_start = 1'b0;
      launch     = 1'b0;
      capture    = 1'b0;
      commit     = 1'b0;
      cnt_inc    = 1'b0;
      case (state)
         IDLE: if (pending != '0) begin
            launch     = 1'b1;
            conv_start = 1'b1;
            state_n    = CONV;
         end
         CONV: if (conv_done) begin
            capture = 1'b1;
            state_n = COMMIT;
         end else if (cnt == TW'(CONV_TMO)) begin
            conv_start = 1'b1;
         end else begin
            cnt_inc = 1'b1;
         end
         COMMIT: if (frame_tick) begin
            commit  = 1'b1;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (!reset) begin
         hit_q    <= '0;
         bonus_q  <= 1'b0;
         pending  <= '0;
         score    <= '0;
         conv_reg <= '0;
         shadow   <= '0;
         disp_bcd <= '0;
         cnt      <= '0;
      end else begin
         hit_q   <= enemy_hit;
         bonus_q <= bonus_hit;
         // events arriving in the launch cycle seed the next pending total
         pending <= launch ? inc : pend_sum;
         cnt     <= cnt_inc ? cnt + TW'(1) : '0;
         if (launch) begin
            score    <= new_score;
            conv_reg <= new_score;
         end
         if (capture) shadow <= conv_bcd;
         if (commit) disp_bcd <= shadow;
      end
   end
endmodule

// File: tb/tb_score_ctrl.sv
// tb_score_ctrl: directed vector table plus hand-written sequences for score_ctrl.
module tb_score_ctrl;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [3:0]  enemy_hit = '0;
   logic        bonus_hit = 1'b0;
   logic        frame_tick = 1'b0;
   logic        conv_done = 1'b0;
   logic [15:0] conv_bcd = '0;
   logic        conv_start;
   logic [13:0] conv_in;
   logic [13:0] score;
   logic [15:0] disp_bcd;
   logic        busy;
   logic        score_maxed;
   int pass = 0, total = 0, fails = 0;
   logic [15:0] last_disp = '0;
   score_ctrl dut (
      .clk(clk), .reset(reset), .enemy_hit(enemy_hit), .bonus_hit(bonus_hit),
      .frame_tick(frame_tick), .conv_done(conv_done), .conv_bcd(conv_bcd),
      .conv_start(conv_start), .conv_in(conv_in), .score(score), .disp_bcd(disp_bcd),
      .busy(busy), .score_maxed(score_maxed)
   );
   always #5 clk = ~clk;
   typedef struct {
      logic [3:0]  en;
      logic        bon;
      logic [15:0] bcd;
      int          dly;
      int          exp;
   } vec_t;
   vec_t vecs [5];
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act == exp) pass++;
      else begin
         fails++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
      end
   endtask
   task automatic txn(input logic [3:0] en, input logic bon, input logic [15:0] bcd,
                      input int dly, input int exp, input bit ck);
      enemy_hit = en;
      bonus_hit = bon;
      step();
      if (ck) begin
         chk("txn_start", int'(conv_start), 1);
         chk("txn_conv_in", int'(conv_in), exp);
      end
      enemy_hit = '0;
      bonus_hit = 1'b0;
      step();
      if (ck) begin
         chk("txn_score", int'(score), exp);
         chk("txn_busy_conv", int'(busy), 1);
      end
      repeat (dly) step();
      conv_done = 1'b1;
      conv_bcd  = bcd;
      step();
      conv_done = 1'b0;
      conv_bcd  = 16'hdead;
      if (ck) chk("txn_disp_hold", int'(disp_bcd), int'(last_disp));
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      last_disp  = bcd;
      if (ck) begin
         chk("txn_disp", int'(disp_bcd), int'(bcd));
         chk("txn_idle", int'(busy), 0);
      end
   endtask
   task automatic wait_start(output int n);
      n = 0;
      do begin
         step();
         n++;
      end while (!conv_start && n < 200);
   endtask
   initial begin
      int n;
      vecs[0] = '{4'b0001, 1'b0, 16'h0010, 20, 10};
      vecs[1] = '{4'b1111, 1'b1, 16'h0100, 3, 100};
      vecs[2] = '{4'b0110, 1'b0, 16'h0120, 0, 120};
      vecs[3] = '{4'b0000, 1'b1, 16'h0170, 5, 170};
      vecs[4] = '{4'b1000, 1'b0, 16'h0180, 62, 180};
      repeat (2) step();
      chk("rst_score", int'(score), 0);
      chk("rst_disp", int'(disp_bcd), 0);
      chk("rst_conv_in", int'(conv_in), 0);
      chk("rst_start", int'(conv_start), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_maxed", int'(score_maxed), 0);
      reset = 1'b1;
      step();
      chk("idle_no_start", int'(conv_start), 0);
      for (int i = 0; i < 5; i++)
         txn(vecs[i].en, vecs[i].bon, vecs[i].bcd, vecs[i].dly, vecs[i].exp, 1'b1);
      // three separate hits while busy collapse into one later start
      enemy_hit = 4'b0001;
      step();
      chk("acc_start", int'(conv_in), 190);
      enemy_hit = 4'b0000; step();
      enemy_hit = 4'b0010; step();
      enemy_hit = 4'b0000; step(); step();
      enemy_hit = 4'b0100; step();
      enemy_hit = 4'b0000; step();
      enemy_hit = 4'b1000; step();
      enemy_hit = 4'b0000; step();
      chk("acc_no_restart", int'(conv_start), 0);
      chk("acc_score_held", int'(score), 190);
      conv_done = 1'b1; conv_bcd = 16'h0190; step();
      conv_done = 1'b1; conv_bcd = 16'h0999; step();
      conv_done = 1'b0;
      chk("acc_commit_busy", int'(busy), 1);
      chk("acc_commit_nostart", int'(conv_start), 0);
      frame_tick = 1'b1; step(); frame_tick = 1'b0;
      chk("acc_disp_shadow", int'(disp_bcd), 16'h0190);
      chk("acc_restart", int'(conv_start), 1);
      chk("acc_conv_in", int'(conv_in), 220);
      step();
      chk("acc_score", int'(score), 220);
      chk("acc_single_pulse", int'(conv_start), 0);
      conv_done = 1'b1; conv_bcd = 16'h0220; step(); conv_done = 1'b0;
      frame_tick = 1'b1; step(); frame_tick = 1'b0;
      chk("acc_disp2", int'(disp_bcd), 16'h0220);
      step();
      chk("acc_idle_quiet", int'(conv_start), 0);
      // converter never answers: start re-pulses every CONV_TMO+1 cycles
      enemy_hit = 4'b0001; step(); enemy_hit = 4'b0000;
      chk("tmo_first", int'(conv_in), 230);
      wait_start(n);
      chk("tmo_gap1", n, 64);
      chk("tmo_conv_in1", int'(conv_in), 230);
      wait_start(n);
      chk("tmo_gap2", n, 64);
      chk("tmo_conv_in2", int'(conv_in), 230);
      conv_done = 1'b1; frame_tick = 1'b1; conv_bcd = 16'h0230; step();
      conv_done = 1'b0; frame_tick = 1'b0;
      chk("same_cycle_commit_wait", int'(busy), 1);
      chk("same_cycle_disp_hold", int'(disp_bcd), 16'h0220);
      frame_tick = 1'b1; step(); frame_tick = 1'b0;
      chk("tmo_disp", int'(disp_bcd), 16'h0230);
      // reset mid-conversion then a late done
      enemy_hit = 4'b0001; step(); enemy_hit = 4'b0000; step(); step();
      reset = 1'b0; step(); reset = 1'b1;
      chk("mid_rst_score", int'(score), 0);
      chk("mid_rst_conv_in", int'(conv_in), 0);
      chk("mid_rst_start", int'(conv_start), 0);
      chk("mid_rst_busy", int'(busy), 0);
      chk("mid_rst_disp", int'(disp_bcd), 0);
      conv_done = 1'b1; conv_bcd = 16'h0240; step(); conv_done = 1'b0;
      chk("late_done_busy", int'(busy), 0);
      frame_tick = 1'b1; step(); frame_tick = 1'b0;
      chk("late_done_disp", int'(disp_bcd), 0);
      // level already high across reset release counts exactly once
      reset = 1'b0; enemy_hit = 4'b0100; step(); step(); reset = 1'b1;
      step();
      chk("held_edge_start", int'(conv_start), 1);
      chk("held_edge_conv_in", int'(conv_in), 10);
      step();
      conv_done = 1'b1; conv_bcd = 16'h0010; step(); conv_done = 1'b0;
      frame_tick = 1'b1; step(); frame_tick = 1'b0;
      step(); step();
      chk("held_once_start", int'(conv_start), 0);
      chk("held_once_score", int'(score), 10);
      enemy_hit = 4'b0000;
      // saturation, starting with the simultaneous-event case from zero
      reset = 1'b0; step(); reset = 1'b1; last_disp = '0;
      txn(4'b1111, 1'b1, 16'h0090, 0, 90, 1'b1);
      for (int i = 0; i < 109; i++) txn(4'b1111, 1'b1, 16'h0000, 0, 90 * (i + 2), 1'b0);
      chk("preload_9900", int'(score), 9900);
      txn(4'b0111, 1'b1, 16'h9980, 0, 9980, 1'b1);
      chk("maxed_9980", int'(score_maxed), 0);
      txn(4'b1111, 1'b0, 16'h9990, 0, 9990, 1'b1);
      chk("maxed_set", int'(score_maxed), 1);
      txn(4'b0001, 1'b0, 16'h9990, 0, 9990, 1'b1);
      chk("maxed_hold_score", int'(score), 9990);
      chk("maxed_hold_flag", int'(score_maxed), 1);
      $display("%0d/%0d checks passed", pass, total);
      $finish;
   end
endmodule

// File: doc/score_ctrl.md
SCORE_CTRL -- requirements
Module: score_ctrl

Interface
REQ-001 Parameters (name, default, meaning): HIT_PTS, 10, points per enemy-hit edge; BONUS_PTS, 50, points per bonus edge; SCORE_MAX, 9990, saturation ceiling; CONV_TMO, 63, cycles to wait for converter done before re-issuing start.
REQ-002 Ports (name direction width meaning):
- clk  in  1  single system clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- enemy_hit  in  4  per-enemy hit level, one bit per enemy.
- bonus_hit  in  1  bonus-pickup level.
- frame_tick  in  1  one-cycle pulse at start of vertical blank.
- conv_done  in  1  one-cycle done pulse from binary-to-BCD converter.
- conv_bcd  in  16  converter result {bcd3,bcd2,bcd1,bcd0}, valid when conv_done=1.
- conv_start  out  1  one-cycle start pulse to converter.
- conv_in  out  14  binary score presented to converter.
- score  out  14  committed binary score.
- disp_bcd  out  16  digits for the score renderer, changed only on frame_tick.
- busy  out  1  high while not in IDLE.
- score_maxed  out  1  high when score = SCORE_MAX.

Function
REQ-003 Rising-edge detection per enemy_hit bit and on bonus_hit, using one registered copy each; a level held high counts once.
REQ-004 Per-cycle increment = HIT_PTS x (number of enemy_hit rising edges, 0-4) + BONUS_PTS x (bonus edge); max 90 per cycle.
REQ-005 Increment added to 14-bit pending accumulator every cycle, in every state; pending saturates at SCORE_MAX.
REQ-006 FSM states: IDLE, CONV, COMMIT.
REQ-007 IDLE, pending != 0: score <= min(score + pending, SCORE_MAX); pending <= that cycle's increment only (same-cycle events not lost); conv_start=1 for exactly that cycle with conv_in = new score; next state CONV.
REQ-008 IDLE, pending = 0: no action; conv_start=0.
REQ-009 conv_in holds its value from start pulse until return to IDLE.
REQ-010 CONV: on conv_done, capture conv_bcd into shadow register, clear timeout counter, go COMMIT.
REQ-011 CONV: timeout counter increments each cycle without conv_done; on reaching CONV_TMO, re-issue one conv_start pulse with same conv_in, clear counter, stay in CONV.
REQ-012 COMMIT: on frame_tick, disp_bcd <= shadow, go IDLE; otherwise hold.
REQ-013 frame_tick and conv_done in the same CONV cycle: capture only; commit waits for next frame_tick.
REQ-014 Latency: event edge at cycle N in IDLE (pending=0) -> conv_start at N+1 -> score updates at N+2 (registered).
REQ-015 Events during CONV/COMMIT accumulate and are applied at the next IDLE visit; at most one score update per frame.
REQ-016 score never exceeds SCORE_MAX; at SCORE_MAX further events still start a conversion of the unchanged value (harmless); score_maxed = (score == SCORE_MAX).
REQ-017 busy = (state != IDLE), combinational from state register.
REQ-018 conv_bcd ignored outside CONV; stray conv_done in IDLE/COMMIT has no effect.

Reset
REQ-019 reset=0 sampled on a rising clk edge: state=IDLE, score=0, pending=0, shadow=0, disp_bcd=0x0000, conv_in=0, conv_start=0, timeout=0, edge registers=0.
REQ-020 Reset mid-CONV or mid-COMMIT aborts without commit; a following late conv_done is ignored.
REQ-021 Edge registers cleared to 0, so an input already high when reset releases counts as one edge on the first active cycle.

Verification
REQ-022 Single hit: enemy_hit[0] 0->1 in IDLE, converter model returns 0x0010 after 20 cycles, frame_tick later -> conv_start one cycle with conv_in=10, score=10, disp_bcd=0x0010 only after frame_tick.
REQ-023 Simultaneous: enemy_hit=4'b1111 and bonus_hit rise together -> score=90, conv_in=90.
REQ-024 Accumulate while busy: hits at 3 separate cycles during CONV -> after commit, exactly one new start with conv_in = old+30.
REQ-025 Saturation: preload score to 9980 via hits, then 4 simultaneous hits -> score=9990, score_maxed=1, further hits leave score 9990.
REQ-026 Timeout: converter model withholds conv_done -> conv_start re-pulses every CONV_TMO+1 cycles with unchanged conv_in; done then completes normally.
REQ-027 Reset mid-CONV: reset=0 for one cycle, then late conv_done -> all outputs at reset values, disp_bcd stays 0x0000.
